// File: rtl/weight_fifo_pkg.sv
// Weight FIFO fill controller: shared FSM state type and default sizing.
// Lane masking is compiled in with WFIFO_LANE_MASK_EN.
package weight_fifo_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } wfifo_state_t;

    localparam int DEF_FIFO_WIDTH = 16;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_SYS_ROW    = 16;
    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_RD_LATENCY = 2;

endpackage

// File: rtl/weight_fifo_fill_ctrl_rd_pipe.sv
// Read-latency delay line: carries issue valid and the active lane mask
// from the memory read strobe to the matching FIFO write strobe.
module wfifo_rd_pipe
    import weight_fifo_pkg::*;
#(
    parameter int LANES = DEF_FIFO_WIDTH,
    parameter int LAT   = DEF_RD_LATENCY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_vld,
    input  logic [LANES-1:0] i_mask,
    output logic [LANES-1:0] o_push,
    output logic             o_busy
);

    logic [LAT-1:0]            r_vld;
    logic [LAT-1:0][LANES-1:0] r_mask;

    // shift issue flags and lane masks toward the FIFO write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld  <= '0;
            r_mask <= '0;
        end else begin
            r_vld[0]  <= i_vld;
            r_mask[0] <= i_mask;
            for (int i = 1; i < LAT; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_mask[i] <= r_mask[i-1];
            end
        end
    end

    assign o_push = r_vld[LAT-1] ? r_mask[LAT-1] : '0;
    assign o_busy = |r_vld;

endmodule

// File: rtl/weight_fifo_fill_ctrl.sv
// Fetches repeat_cnt*SYS_ROW weight rows into per-lane FIFOs, credit-gated.
// Define WFIFO_LANE_MASK_EN to add the lane_mask input.
module weight_fifo_fill_ctrl
    import weight_fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int SYS_ROW    = DEF_SYS_ROW,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RD_LATENCY = DEF_RD_LATENCY
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [31:0]                          repeat_cnt,
    input  logic [ADDR_WIDTH-1:0]                base_addr,
    input  logic [ADDR_WIDTH-1:0]                offset_addr,
    input  logic [ADDR_WIDTH-1:0]                lane_stride,
`ifdef WFIFO_LANE_MASK_EN
    input  logic [FIFO_WIDTH-1:0]                lane_mask,
`endif
    input  logic                                 fifo_pop,
    output logic [FIFO_WIDTH-1:0]                w_mem_rd_en,
    output logic [FIFO_WIDTH-1:0][ADDR_WIDTH-1:0] w_mem_rd_addr,
    output logic [FIFO_WIDTH-1:0]                fifo_push,
    output logic                                 busy,
    output logic                                 done
);

    localparam int SR_LOG2 = $clog2(SYS_ROW);
    localparam int CNT_W   = 32 + SR_LOG2;
    localparam int CRD_W   = $clog2(FIFO_DEPTH) + 1;

    wfifo_state_t          r_state;
    wfifo_state_t          w_next;
    logic [CNT_W-1:0]      r_total;
    logic [CNT_W-1:0]      r_k;
    logic [ADDR_WIDTH-1:0] r_base_off;
    logic [ADDR_WIDTH-1:0] r_stride;
    logic [CRD_W-1:0]      r_credit;
    logic                  r_zero_done;
    logic [FIFO_WIDTH-1:0] w_mask;
    logic                  w_accept;
    logic                  w_issue;
    logic                  w_last;
    logic                  w_pop_eff;
    logic                  w_inflight;

    assign w_accept  = start && (r_state == S_IDLE);
    assign w_issue   = (r_state == S_ISSUE) && (r_credit != '0);
    assign w_last    = w_issue && (r_k == r_total - CNT_W'(1));
    assign w_pop_eff = fifo_pop &&
                       ((r_credit != CRD_W'(FIFO_DEPTH)) || w_issue);

`ifdef WFIFO_LANE_MASK_EN
    logic [FIFO_WIDTH-1:0] r_mask;

    // capture the active lane set for the whole job
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask <= '0;
        end else if (w_accept) begin
            r_mask <= lane_mask;
        end
    end

    assign w_mask = r_mask;
`else
    assign w_mask = '1;
`endif

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next state, busy and completion pulse
    always_comb begin
        w_next = r_state;
        busy   = (r_state != S_IDLE);
        done   = r_zero_done;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept && (repeat_cnt != '0)) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_last) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!w_inflight) begin
                    w_next = S_IDLE;
                    done   = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // job parameters and issue index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_total     <= '0;
            r_k         <= '0;
            r_base_off  <= '0;
            r_stride    <= '0;
            r_zero_done <= 1'b0;
        end else begin
            r_zero_done <= w_accept && (repeat_cnt == '0);
            if (w_accept) begin
                r_total    <= CNT_W'(repeat_cnt) << SR_LOG2;
                r_k        <= '0;
                r_base_off <= base_addr + offset_addr;
                r_stride   <= lane_stride;
            end else if (w_issue) begin
                r_k <= r_k + CNT_W'(1);
            end
        end
    end

    // FIFO space credits: one per issue taken, one per pop returned
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credit <= CRD_W'(FIFO_DEPTH);
        end else if (w_issue && !w_pop_eff) begin
            r_credit <= r_credit - CRD_W'(1);
        end else if (!w_issue && w_pop_eff) begin
            r_credit <= r_credit + CRD_W'(1);
        end
    end

    // per-lane read strobes and addresses, zero on idle lanes
    always_comb begin
        w_mem_rd_en   = w_issue ? w_mask : '0;
        w_mem_rd_addr = '0;
        for (int i = 0; i < FIFO_WIDTH; i++) begin
            if (w_mem_rd_en[i]) begin
                w_mem_rd_addr[i] = r_base_off
                                 + ADDR_WIDTH'(i) * r_stride
                                 + r_k[ADDR_WIDTH-1:0];
            end
        end
    end

    wfifo_rd_pipe #(
        .LANES (FIFO_WIDTH),
        .LAT   (RD_LATENCY)
    ) u_rd_pipe (
        .clk    (clk),
        .rst    (rst),
        .i_vld  (w_issue),
        .i_mask (w_mask),
        .o_push (fifo_push),
        .o_busy (w_inflight)
    );

endmodule

// File: tb/tb_weight_fifo_fill_ctrl.sv
// Directed bench for weight_fifo_fill_ctrl (default 16-lane configuration).
// Lane-mask vectors are included when WFIFO_LANE_MASK_EN is defined.
module tb_weight_fifo_fill_ctrl;

    localparam int LAT = 2;

    logic              clk;
    logic              rst;
    logic              start;
    logic [31:0]       repeat_cnt;
    logic [15:0]       base_addr;
    logic [15:0]       offset_addr;
    logic [15:0]       lane_stride;
    logic              fifo_pop;
    logic [15:0]       rd_en;
    logic [15:0][15:0] rd_addr;
    logic [15:0]       push;
    logic              busy;
    logic              done;
`ifdef WFIFO_LANE_MASK_EN
    logic [15:0]       lane_mask;
`endif

    int n_vec;
    int n_bad;

    logic        mon_clr;
    int          cyc;
    int          n_rd, n_push, n_done, n_busy;
    int          start_cyc, done_cyc, last_push_cyc;
    int          az_err, push_err;
    logic [15:0] or_rd, or_push;
    logic [15:0] log0 [64];
    logic [15:0] log3 [64];
    logic [15:0] exp_p [LAT];
    int          p0, d0;

    weight_fifo_fill_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .repeat_cnt    (repeat_cnt),
        .base_addr     (base_addr),
        .offset_addr   (offset_addr),
        .lane_stride   (lane_stride),
`ifdef WFIFO_LANE_MASK_EN
        .lane_mask     (lane_mask),
`endif
        .fifo_pop      (fifo_pop),
        .w_mem_rd_en   (rd_en),
        .w_mem_rd_addr (rd_addr),
        .fifo_push     (push),
        .busy          (busy),
        .done          (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // observe outputs mid-cycle and keep a reference push pipeline
    always @(negedge clk) begin
        cyc++;
        if (mon_clr) begin
            n_rd = 0; n_push = 0; n_done = 0; n_busy = 0;
            start_cyc = -1; done_cyc = -1; last_push_cyc = -1;
            az_err = 0; push_err = 0; or_rd = '0; or_push = '0;
        end else begin
            if (start && !busy && start_cyc < 0) start_cyc = cyc;
            if (rd_en != '0) begin
                if (n_rd < 64) begin
                    log0[n_rd] = rd_addr[0];
                    log3[n_rd] = rd_addr[3];
                end
                n_rd++;
            end
            if (push != '0) begin
                n_push++;
                last_push_cyc = cyc;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (busy) n_busy++;
            or_rd   = or_rd | rd_en;
            or_push = or_push | push;
            for (int i = 0; i < 16; i++)
                if (!rd_en[i] && rd_addr[i] != '0) az_err++;
        end
        if (rst) begin
            for (int i = 0; i < LAT; i++) exp_p[i] = '0;
        end else begin
            if (push != exp_p[LAT-1]) push_err++;
            for (int i = LAT - 1; i > 0; i--) exp_p[i] = exp_p[i-1];
            exp_p[0] = rd_en;
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
        tick();
    endtask

    task automatic kick(input logic [31:0] cnt, input logic [15:0] b,
                        input logic [15:0] o, input logic [15:0] s);
        repeat_cnt  = cnt;
        base_addr   = b;
        offset_addr = o;
        lane_stride = s;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (n_done != 0) break;
            tick();
        end
        repeat (6) tick();
    endtask

    initial begin
        n_vec = 0; n_bad = 0; cyc = 0; mon_clr = 1'b0;
        n_rd = 0; n_push = 0; n_done = 0; n_busy = 0;
        start_cyc = -1; done_cyc = -1; last_push_cyc = -1;
        az_err = 0; push_err = 0; or_rd = '0; or_push = '0;
        for (int i = 0; i < LAT; i++) exp_p[i] = '0;
        rst = 1'b1; start = 1'b0; repeat_cnt = '0;
        base_addr = '0; offset_addr = '0; lane_stride = '0;
        fifo_pop = 1'b0;
`ifdef WFIFO_LANE_MASK_EN
        lane_mask = 16'hFFFF;
`endif
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rden", rd_en, 0);
        check("rst_push", push, 0);
        check("rst_addr", rd_addr, 0);
        rst = 1'b0;
        tick();

        // full job, pop every cycle, second start mid-job ignored
        fifo_pop = 1'b1;
        clr_mon();
        kick(2, 16'h0100, 16'h0010, 16'h0040);
        repeat (4) tick();
        kick(5, 16'h3000, 16'h0000, 16'h0001);
        wait_done(200);
        check("j1_reads", n_rd, 32);
        check("j1_pushes", n_push, 32);
        check("j1_done", n_done, 1);
        check("j1_l3_first", log3[0], 16'h01D0);
        check("j1_l3_last", log3[31], 16'h01EF);
        check("j1_l0_first", log0[0], 16'h0110);
        check("j1_lat", done_cyc - start_cyc, 35);
        check("j1_done_after_push", done_cyc - last_push_cyc, 1);
        check("j1_busy_span", n_busy, 35);
        check("j1_push_align", push_err, 0);
        check("j1_addr_zero", az_err, 0);
        check("j1_lanes", or_rd, 16'hFFFF);

        // credit stall without pops, then resume
        fifo_pop = 1'b0;
        clr_mon();
        kick(2, 16'h0000, 16'h0000, 16'h0001);
        repeat (40) tick();
        check("j2_stall_reads", n_rd, 16);
        check("j2_stall_busy", busy, 1);
        check("j2_stall_done", n_done, 0);
        fifo_pop = 1'b1;
        wait_done(200);
        check("j2_reads", n_rd, 32);
        check("j2_pushes", n_push, 32);
        check("j2_done", n_done, 1);
        check("j2_resume_addr", log0[16], 16'h0010);
        check("j2_hold_addr", log0[15], 16'h000F);
        check("j2_done_after_push", done_cyc - last_push_cyc, 1);
        check("j2_push_align", push_err, 0);
        repeat (20) tick();

        // zero-length job
        clr_mon();
        kick(0, 16'h0100, 16'h0000, 16'h0001);
        repeat (5) tick();
        check("j0_done_lat", done_cyc - start_cyc, 1);
        check("j0_done", n_done, 1);
        check("j0_busy", n_busy, 0);
        check("j0_reads", n_rd, 0);

        // address wrap
        clr_mon();
        kick(1, 16'hFFF8, 16'h0000, 16'h0000);
        wait_done(200);
        check("wr_reads", n_rd, 16);
        check("wr_a0", log0[0], 16'hFFF8);
        check("wr_a7", log0[7], 16'hFFFF);
        check("wr_a8", log0[8], 16'h0000);
        check("wr_a15", log0[15], 16'h0007);
        check("wr_l3_a8", log3[8], 16'h0000);

        // reset mid-job
        clr_mon();
        kick(2, 16'h0100, 16'h0000, 16'h0040);
        for (int i = 0; i < 50; i++) begin
            if (n_rd >= 5) break;
            tick();
        end
        p0 = n_push;
        d0 = n_done;
        rst = 1'b1;
        #2;
        check("mr_rden", rd_en, 0);
        check("mr_push", push, 0);
        check("mr_busy", busy, 0);
        check("mr_done", done, 0);
        check("mr_addr", rd_addr, 0);
        tick();
        rst = 1'b0;
        repeat (10) tick();
        check("mr_no_push", n_push - p0, 0);
        check("mr_no_done", n_done - d0, 0);
        clr_mon();
        kick(2, 16'h0100, 16'h0000, 16'h0040);
        wait_done(200);
        check("mr_reads", n_rd, 32);
        check("mr_pushes", n_push, 32);
        check("mr_done_cnt", n_done, 1);

`ifdef WFIFO_LANE_MASK_EN
        lane_mask = 16'h0005;
        clr_mon();
        kick(1, 16'h0000, 16'h0000, 16'h0001);
        lane_mask = 16'hFFFF;
        wait_done(200);
        check("lm_rden", or_rd, 16'h0005);
        check("lm_push", or_push, 16'h0005);
        check("lm_reads", n_rd, 16);
        check("lm_done", n_done, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
